// File: rtl/counter.sv
// rtl/counter.sv - stopwatch seconds counter: clk prescaler to 1 Hz tick, packed BCD 00-59
module counter #(
  parameter int CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       init_regs,
  input  logic       count_enabled,
  output logic [7:0] time_reading
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          tick;

  always_comb begin
    presc_d = presc_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    tick    = count_enabled && (presc_q == PRESC_LAST);

    // Pausing holds the prescaler so a resumed run finishes the partial second.
    if (count_enabled) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      if (ones_q != 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else begin
        ones_d = 4'd0;
        tens_d = (tens_q == 4'd5) ? 4'd0 : tens_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge init_regs) begin
    if (init_regs) begin
      presc_q <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
    end else begin
      presc_q <= presc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  assign time_reading = {tens_q, ones_q};

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for counter with a small CLK_FREQ override
module tb_counter;

  localparam int F = 10;

  logic       clk;
  logic       init_regs;
  logic       count_enabled;
  logic [7:0] time_reading;

  int vectors;
  int miscompares;
  int en_edges;  // enabled rising edges since the last reset release

  counter #(.CLK_FREQ(F)) dut (
    .clk           (clk),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .time_reading  (time_reading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int s);
    int m;
    m = s % 60;
    return 8'(((m / 10) * 16) + (m % 10));
  endfunction

  function automatic logic [7:0] model_reading();
    return bcd(en_edges / F);
  endfunction

  task automatic step(input logic en);
    count_enabled = en;
    @(posedge clk);
    if (en) en_edges++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    init_regs = 1'b1;
    @(negedge clk);
    en_edges  = 0;
    init_regs = 1'b0;
  endtask

  task automatic test_reset();
    count_enabled = 1'b1;
    init_regs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (time_reading !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %h want 00", i, time_reading);
      end
    end
    init_regs = 1'b0;
    en_edges = 0;
    for (int i = 0; i < 25; i++) step(1'b1);
    vectors++;
    if (time_reading !== 8'h02) begin
      miscompares++;
      $display("FAIL reset_precount: got %h want 02", time_reading);
    end
    #2 init_regs = 1'b1;
    #1;
    vectors++;
    if (time_reading !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: got %h want 00", time_reading);
    end
    @(negedge clk);
    init_regs = 1'b0;
    en_edges = 0;
  endtask

  task automatic test_basic_count();
    do_reset();
    for (int e = 1; e <= F; e++) begin
      step(1'b1);
      vectors++;
      if (time_reading !== ((e < F) ? 8'h00 : 8'h01)) begin
        miscompares++;
        $display("FAIL basic_latency edge %0d: got %h want %h", e, time_reading,
                 (e < F) ? 8'h00 : 8'h01);
      end
    end
    for (int s = 2; s <= 19; s++) begin
      for (int k = 0; k < F; k++) step(1'b1);
      vectors++;
      if (time_reading !== bcd(s)) begin
        miscompares++;
        $display("FAIL basic_seq sec %0d: got %h want %h", s, time_reading, bcd(s));
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      vectors++;
      if (time_reading !== 8'h00) begin
        miscompares++;
        $display("FAIL pause_hold edge %0d: got %h want 00", i, time_reading);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      vectors++;
      if (time_reading !== ((i < 6) ? 8'h00 : 8'h01)) begin
        miscompares++;
        $display("FAIL pause_resume edge %0d: got %h want %h", i, time_reading,
                 (i < 6) ? 8'h00 : 8'h01);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 59 * F; i++) step(1'b1);
    vectors++;
    if (time_reading !== 8'h59) begin
      miscompares++;
      $display("FAIL wrap_59: got %h want 59", time_reading);
    end
    for (int i = 0; i < F; i++) step(1'b1);
    vectors++;
    if (time_reading !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_00: got %h want 00", time_reading);
    end
    for (int i = 0; i < F; i++) step(1'b1);
    vectors++;
    if (time_reading !== 8'h01) begin
      miscompares++;
      $display("FAIL wrap_01: got %h want 01", time_reading);
    end
  endtask

  task automatic test_reset_mid_second();
    do_reset();
    for (int i = 0; i < 23 * F + 7; i++) step(1'b1);
    vectors++;
    if (time_reading !== 8'h23) begin
      miscompares++;
      $display("FAIL midsec_pre: got %h want 23", time_reading);
    end
    #3 init_regs = 1'b1;
    #1;
    vectors++;
    if (time_reading !== 8'h00) begin
      miscompares++;
      $display("FAIL midsec_reset: got %h want 00", time_reading);
    end
    @(negedge clk);
    init_regs = 1'b0;
    en_edges = 0;
    for (int e = 1; e <= F; e++) begin
      step(1'b1);
      vectors++;
      if (time_reading !== ((e < F) ? 8'h00 : 8'h01)) begin
        miscompares++;
        $display("FAIL midsec_full edge %0d: got %h want %h", e, time_reading,
                 (e < F) ? 8'h00 : 8'h01);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end
      vectors++;
      if (time_reading !== model_reading()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h want %h", i, time_reading, model_reading());
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    en_edges      = 0;
    init_regs     = 1'b1;
    count_enabled = 1'b0;
    #3;
    test_reset();
    test_basic_count();
    test_pause();
    test_wrap();
    test_reset_mid_second();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
